hilo_fwd_file: RTL and testbench
================================

// Module: hilo_fwd_file
// PURPOSE
//  Parametrised successor of the HI/LO special-register block: NCH architectural registers
//  (ch0=HI, ch1=LO by default), each with NSTG-deep priority forwarding and a registered,
//  stall-aware ID->EX read port.
//  Adds a per-channel pending scoreboard for multi-cycle mul/div, with a read-stall request
//  and a flush. Sits beside the GPR file; fed by EX/MEM/... stages and the WB commit bus.
// PARAMETERS
//  DW       32  data width per channel
//  NCH      2   number of channels (registers)
//  NSTG     3   forwarding stages; stage 0 = youngest (EX), NSTG-1 = oldest before WB
//  STALL_W  6   width of pipeline stall bus
//  RD_STG   2   stall-bus index of read stage; RD_STG+1 is the next stage
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              asynchronous reset, ACTIVE-LOW
//  stall        in   STALL_W        pipeline stall vector, 1 = stop
//  flush        in   1              pipeline flush (exception)
//  stg_we       in   NSTG*NCH       in-flight write enables, bit [s*NCH+c]
//  stg_wdata    in   NSTG*NCH*DW    in-flight write data, slice [(s*NCH+c)*DW +: DW]
//  commit_we    in   NCH            WB commit enables
//  commit_wdata in   NCH*DW         WB commit data, slice [c*DW +: DW]
//  lock_set     in   NCH            multi-cycle op issued that will write channel c
//  rd_req       in   1              read-stage instruction reads special regs
//  rd_sel       in   NCH            channels read by that instruction
//  rd_data      out  NCH*DW         registered forwarded read data to next stage
//  pending      out  NCH            scoreboard bits (registered)
//  stallreq     out  1              combinational stall request to pipeline controller
//  arch_data    out  NCH*DW         architectural register values (debug/trace)
// BEHAVIOUR
//  - Reset (rst=0, async): all arch regs, rd_data, pending = 0. Release is synchronous to clk.
//  - Commit: posedge with commit_we[c]=1 -> arch[c] <= commit_wdata[c]; otherwise hold.
//    Unaffected by flush and stall.
//  - Forward value per channel, combinational, fixed priority:
//    stage 0 > stage 1 > ... > stage NSTG-1 > commit bus > arch[c].
//    Each level is taken only if its we bit is set.
//  - rd_data register, priority order:
//    flush -> 0;
//    stall[RD_STG]=1 & stall[RD_STG+1]=0 -> 0 (bubble);
//    stall[RD_STG]=0 -> forward values, all channels;
//    else hold. Latency: read port to rd_data is 1 cycle.
//  - Scoreboard per channel, next-state priority:
//    flush -> 0; lock_set[c] -> 1 (wins over same-cycle commit, i.e. new op);
//    commit_we[c] -> 0; else hold.
//  - stallreq = rd_req & |(rd_sel & pending) & ~flush. It reads the registered pending bits,
//    so a commit releases the stall the cycle after commit_we. The reader sees the committed
//    value through arch[c] at that point.
//  - While stallreq=1, the controller is expected to assert stall[RD_STG]. The block itself
//    does not gate rd_data on stallreq.
//  - No arithmetic; all widths exact, no truncation. NSTG>=1, NCH>=1, RD_STG+1<STALL_W.
//  - Reset mid-operation: pending and rd_data clear immediately. In-flight stage inputs are
//    ignored until release.
// TESTING
//  1 reset: hold rst=0 with random inputs -> rd_data=0, pending=0, arch_data=0, stallreq=0.
//  2 priority: arch HI=0x11, commit 0x22, stg2 0x33, stg0 0x44, stall=0
//    -> next rd_data HI=0x44; drop stg0 -> 0x33; drop stg2 -> 0x22; drop commit -> 0x22 (now arch).
//  3 bubble/hold: stall[2]=1, stall[3]=0 -> rd_data=0;
//    stall[3:2]=2'b11 with prior 0x55 -> stays 0x55.
//  4 scoreboard: lock_set[LO]; next cycle rd_req=1, rd_sel=LO -> stallreq=1;
//    commit LO=0xABCD -> stallreq=0 one cycle later, rd_data LO=0xABCD.
//  5 simultaneous: lock_set[HI] and commit_we[HI] same cycle -> pending[HI]=1,
//    arch HI updated; rd_sel=HI stalls.
//  6 flush: pending=2'b11, flush=1 with commit_we=HI (0x77)
//    -> pending=0, rd_data=0, arch HI=0x77, stallreq=0 during flush.

Source files
------------

// File: rtl/hilo_fwd_file_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_fwd_file_if
// Description : Bundles the pipeline-facing signals of the HI/LO forwarding file.
//               master = pipeline/controller side, slave = register block side.
//               Pipeline -> block : stall, flush, stg_we/stg_wdata, commit_we/
//                                   commit_wdata, lock_set, rd_req, rd_sel
//               Block -> pipeline : rd_data, pending, stallreq, arch_data
// Revision    : 1.0  initial release
// ============================================================================
interface hilo_fwd_file_if #(
  parameter int DW      = 32,
  parameter int NCH     = 2,
  parameter int NSTG    = 3,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0]      stall;
  logic                    flush;
  logic [NSTG*NCH-1:0]     stg_we;
  logic [NSTG*NCH*DW-1:0]  stg_wdata;
  logic [NCH-1:0]          commit_we;
  logic [NCH*DW-1:0]       commit_wdata;
  logic [NCH-1:0]          lock_set;
  logic                    rd_req;
  logic [NCH-1:0]          rd_sel;
  logic [NCH*DW-1:0]       rd_data;
  logic [NCH-1:0]          pending;
  logic                    stallreq;
  logic [NCH*DW-1:0]       arch_data;

  modport master (
    output stall, flush, stg_we, stg_wdata, commit_we, commit_wdata,
           lock_set, rd_req, rd_sel,
    input  rd_data, pending, stallreq, arch_data
  );

  modport slave (
    input  stall, flush, stg_we, stg_wdata, commit_we, commit_wdata,
           lock_set, rd_req, rd_sel,
    output rd_data, pending, stallreq, arch_data
  );
endinterface
`default_nettype wire

// File: rtl/hilo_fwd_file.sv
`default_nettype none
// ============================================================================
// Module      : hilo_fwd_file
// Description : NCH special registers (ch0 = HI, ch1 = LO) with NSTG-deep
//               priority forwarding, a registered stall-aware read port and a
//               per-channel pending scoreboard for multi-cycle mul/div.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous reset, active low
//               bus  - hilo_fwd_file_if.slave (pipeline signals, see interface)
// Revision    : 1.0  initial release
// ============================================================================
module hilo_fwd_file #(
  parameter int DW      = 32,
  parameter int NCH     = 2,
  parameter int NSTG    = 3,
  parameter int STALL_W = 6,
  parameter int RD_STG  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  hilo_fwd_file_if.slave       bus
);

  logic [NCH*DW-1:0] arch_reg;
  logic [NCH*DW-1:0] fwd;
  logic [NCH*DW-1:0] rd_reg;
  logic [NCH-1:0]    pend_reg;

  // Only the read stage and the stage after it matter for the read port.
  logic unused_stall;
  assign unused_stall = ^bus.stall;

  logic stall_rd;
  logic stall_nx;
  assign stall_rd = bus.stall[RD_STG];
  assign stall_nx = bus.stall[RD_STG+1];

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [DW-1:0] arch_c;
      logic [DW-1:0] fwd_c;
      logic          pend_c;

      // Architectural register: written only by the WB commit bus.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          arch_c <= '0;
        end else if (bus.commit_we[c]) begin
          arch_c <= bus.commit_wdata[c*DW +: DW];
        end
      end

      // Forwarding: start from the lowest priority source and let each
      // younger source overwrite, so stage 0 ends up winning.
      always_comb begin
        fwd_c = arch_c;
        if (bus.commit_we[c]) begin
          fwd_c = bus.commit_wdata[c*DW +: DW];
        end
        for (int s = NSTG - 1; s >= 0; s--) begin
          if (bus.stg_we[s*NCH + c]) begin
            fwd_c = bus.stg_wdata[(s*NCH + c)*DW +: DW];
          end
        end
      end

      // Scoreboard: a new lock beats a same-cycle commit, since the commit
      // belongs to the older op and the new op still has to write.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pend_c <= 1'b0;
        end else if (bus.flush) begin
          pend_c <= 1'b0;
        end else if (bus.lock_set[c]) begin
          pend_c <= 1'b1;
        end else if (bus.commit_we[c]) begin
          pend_c <= 1'b0;
        end
      end

      assign arch_reg[c*DW +: DW] = arch_c;
      assign fwd[c*DW +: DW]      = fwd_c;
      assign pend_reg[c]          = pend_c;
    end
  endgenerate

  // Read port: a stalled read stage feeding a moving next stage emits a
  // bubble; a stalled read stage behind a stalled next stage holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_reg <= '0;
    end else if (bus.flush) begin
      rd_reg <= '0;
    end else if (stall_rd && !stall_nx) begin
      rd_reg <= '0;
    end else if (!stall_rd) begin
      rd_reg <= fwd;
    end
  end

  // Uses registered pending bits, so a commit releases the stall one cycle
  // later, when the committed value is already visible in the arch register.
  assign bus.stallreq  = bus.rd_req & (|(bus.rd_sel & pend_reg)) & ~bus.flush;
  assign bus.rd_data   = rd_reg;
  assign bus.pending   = pend_reg;
  assign bus.arch_data = arch_reg;

endmodule
`default_nettype wire

// File: tb/tb_hilo_fwd_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_fwd_file
// Description : Self-checking bench for hilo_fwd_file. Expected post-edge
//               state is queued when inputs are applied and compared after
//               the clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_fwd_file;
  localparam int DW      = 32;
  localparam int NCH     = 2;
  localparam int NSTG    = 3;
  localparam int STALL_W = 6;
  localparam int RD_STG  = 2;
  localparam int VW      = NCH * DW;

  typedef struct {
    logic [VW-1:0]  rd;
    logic [NCH-1:0] pend;
    logic [VW-1:0]  arch;
  } exp_t;

  logic clk;
  logic rst;

  hilo_fwd_file_if #(.DW(DW), .NCH(NCH), .NSTG(NSTG), .STALL_W(STALL_W)) bus ();

  hilo_fwd_file #(
    .DW(DW), .NCH(NCH), .NSTG(NSTG), .STALL_W(STALL_W), .RD_STG(RD_STG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t           sbq[$];
  logic [VW-1:0]  m_arch;
  logic [VW-1:0]  m_rd;
  logic [NCH-1:0] m_pend;
  int             n_vec;
  int             n_err;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.stall        = '0;
    bus.flush        = 1'b0;
    bus.stg_we       = '0;
    bus.stg_wdata    = '0;
    bus.commit_we    = '0;
    bus.commit_wdata = '0;
    bus.lock_set     = '0;
    bus.rd_req       = 1'b0;
    bus.rd_sel       = '0;
  endtask

  task automatic random_inputs(input bit allow_flush);
    bus.stall     = STALL_W'($urandom);
    bus.flush     = allow_flush && ($urandom_range(0, 9) == 0);
    bus.stg_we    = (NSTG*NCH)'($urandom);
    for (int i = 0; i < NSTG*NCH; i++) bus.stg_wdata[i*DW +: DW] = $urandom;
    bus.commit_we = NCH'($urandom);
    for (int i = 0; i < NCH; i++) bus.commit_wdata[i*DW +: DW] = $urandom;
    bus.lock_set  = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
    bus.rd_req    = 1'($urandom);
    bus.rd_sel    = NCH'($urandom);
  endtask

  // Checks stallreq for the current inputs, queues the expected post-edge
  // state, clocks once and compares.
  task automatic tick(input string tag);
    exp_t          e;
    exp_t          got;
    logic [DW-1:0] f;
    logic          exp_sr;
    #1;
    exp_sr = bus.rd_req & (|(bus.rd_sel & m_pend)) & ~bus.flush;
    check_val({tag, "/stallreq"}, 64'(bus.stallreq), 64'(exp_sr));
    e.rd   = m_rd;
    e.pend = m_pend;
    e.arch = m_arch;
    for (int c = 0; c < NCH; c++) begin
      f = m_arch[c*DW +: DW];
      if (bus.commit_we[c]) f = bus.commit_wdata[c*DW +: DW];
      for (int s = NSTG - 1; s >= 0; s--)
        if (bus.stg_we[s*NCH + c]) f = bus.stg_wdata[(s*NCH + c)*DW +: DW];
      if (bus.commit_we[c]) e.arch[c*DW +: DW] = bus.commit_wdata[c*DW +: DW];
      if (bus.flush)            e.pend[c] = 1'b0;
      else if (bus.lock_set[c]) e.pend[c] = 1'b1;
      else if (bus.commit_we[c]) e.pend[c] = 1'b0;
      if (!bus.stall[RD_STG]) e.rd[c*DW +: DW] = f;
    end
    if (bus.flush) e.rd = '0;
    else if (bus.stall[RD_STG] && !bus.stall[RD_STG+1]) e.rd = '0;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    check_val({tag, "/rd_data"},   64'(bus.rd_data),   64'(got.rd));
    check_val({tag, "/pending"},   64'(bus.pending),   64'(got.pend));
    check_val({tag, "/arch_data"}, 64'(bus.arch_data), 64'(got.arch));
    m_rd   = got.rd;
    m_pend = got.pend;
    m_arch = got.arch;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    m_arch = '0;
    m_rd   = '0;
    m_pend = '0;

    // 1: reset held with random inputs
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      random_inputs(1'b1);
      @(posedge clk);
      #1;
      check_val("reset/rd_data",   64'(bus.rd_data),   64'h0);
      check_val("reset/pending",   64'(bus.pending),   64'h0);
      check_val("reset/arch_data", 64'(bus.arch_data), 64'h0);
      check_val("reset/stallreq",  64'(bus.stallreq),  64'h0);
    end
    idle_inputs();
    rst = 1'b1;

    // 2: forwarding priority on HI
    bus.commit_we = 2'b01; bus.commit_wdata[31:0] = 32'h11;
    tick("prio_arch");
    bus.commit_wdata[31:0] = 32'h22;
    bus.stg_we[2*NCH + 0] = 1'b1; bus.stg_wdata[(2*NCH + 0)*DW +: DW] = 32'h33;
    bus.stg_we[0]         = 1'b1; bus.stg_wdata[0 +: DW]              = 32'h44;
    tick("prio_stg0");
    check_val("prio_stg0_const", 64'(bus.rd_data[31:0]), 64'h44);
    bus.stg_we[0] = 1'b0;
    tick("prio_stg2");
    check_val("prio_stg2_const", 64'(bus.rd_data[31:0]), 64'h33);
    bus.stg_we[2*NCH + 0] = 1'b0;
    tick("prio_commit");
    check_val("prio_commit_const", 64'(bus.rd_data[31:0]), 64'h22);
    bus.commit_we = '0;
    tick("prio_arch2");
    check_val("prio_arch_const", 64'(bus.rd_data[31:0]), 64'h22);

    // 3: bubble then hold
    bus.stall = 6'b000100;
    tick("bubble");
    check_val("bubble_const", 64'(bus.rd_data), 64'h0);
    bus.stall = '0; bus.commit_we = 2'b01; bus.commit_wdata[31:0] = 32'h55;
    tick("load55");
    bus.commit_we = '0; bus.stall = 6'b001100;
    bus.stg_we[0] = 1'b1; bus.stg_wdata[0 +: DW] = 32'h99;
    tick("hold");
    check_val("hold_const", 64'(bus.rd_data[31:0]), 64'h55);
    idle_inputs();

    // 4: scoreboard on LO
    bus.lock_set = 2'b10;
    tick("lock_lo");
    bus.lock_set = '0; bus.rd_req = 1'b1; bus.rd_sel = 2'b10; bus.stall = 6'b000100;
    #1;
    check_val("lo_stallreq_const", 64'(bus.stallreq), 64'h1);
    tick("lo_wait");
    bus.commit_we = 2'b10; bus.commit_wdata[63:32] = 32'hABCD;
    tick("lo_commit");
    bus.commit_we = '0; bus.stall = '0;
    #1;
    check_val("lo_release_const", 64'(bus.stallreq), 64'h0);
    tick("lo_read");
    check_val("lo_data_const", 64'(bus.rd_data[63:32]), 64'hABCD);
    idle_inputs();

    // 5: simultaneous lock and commit on HI
    bus.lock_set = 2'b01; bus.commit_we = 2'b01; bus.commit_wdata[31:0] = 32'h66;
    tick("simul");
    check_val("simul_pend_const", 64'(bus.pending), 64'h1);
    check_val("simul_arch_const", 64'(bus.arch_data[31:0]), 64'h66);
    idle_inputs();
    bus.rd_req = 1'b1; bus.rd_sel = 2'b01; bus.stall = 6'b000100;
    #1;
    check_val("simul_stall_const", 64'(bus.stallreq), 64'h1);
    tick("simul_stall");
    idle_inputs();

    // 6: flush
    bus.lock_set = 2'b11;
    tick("lock_both");
    bus.lock_set = '0; bus.flush = 1'b1; bus.commit_we = 2'b01;
    bus.commit_wdata[31:0] = 32'h77; bus.rd_req = 1'b1; bus.rd_sel = 2'b11;
    #1;
    check_val("flush_stallreq_const", 64'(bus.stallreq), 64'h0);
    tick("flush");
    check_val("flush_pend_const", 64'(bus.pending), 64'h0);
    check_val("flush_rd_const",   64'(bus.rd_data), 64'h0);
    check_val("flush_arch_const", 64'(bus.arch_data[31:0]), 64'h77);
    idle_inputs();

    // 7: asynchronous reset mid-operation
    bus.lock_set = 2'b11; bus.stg_we[1] = 1'b1; bus.stg_wdata[DW +: DW] = 32'hBEEF;
    tick("pre_rst");
    #2;
    rst = 1'b0;
    #1;
    check_val("async_rst/rd_data", 64'(bus.rd_data),   64'h0);
    check_val("async_rst/pending", 64'(bus.pending),   64'h0);
    check_val("async_rst/arch",    64'(bus.arch_data), 64'h0);
    random_inputs(1'b0);
    @(posedge clk);
    #1;
    check_val("async_rst/held_rd", 64'(bus.rd_data), 64'h0);
    idle_inputs();
    rst    = 1'b1;
    m_arch = '0;
    m_rd   = '0;
    m_pend = '0;

    // 8: random traffic against the model
    for (int i = 0; i < 300; i++) begin
      random_inputs(1'b1);
      tick("random");
    end

    if (sbq.size() != 0) check_val("sbq_empty", 64'(sbq.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
